// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Purpose: shared 640x480 @ 60 Hz VGA timing constants, the raster position
//          payload type and a window-test helper. Used by the timing generator
//          and by the game logic for its active-window bounds.
// Ports:   none (package)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned VGA_CNT_W       = 10;   // enough for totals <= 1024

  localparam int unsigned VGA_CLK_DIV     = 4;    // 100 MHz / 4 = 25 MHz pixel
  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_ACT_START = 144;
  localparam int unsigned VGA_H_ACT_END   = 784;
  localparam int unsigned VGA_V_TOTAL     = 525;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_ACT_START = 35;
  localparam int unsigned VGA_V_ACT_END   = 515;

  // Raster position payload (line, column)
  typedef struct packed {
    logic [VGA_CNT_W-1:0] v;
    logic [VGA_CNT_W-1:0] h;
  } vga_pos_t;

  // True when lo <= pos < hi
  function automatic logic in_window(input logic [VGA_CNT_W-1:0] pos,
                                     input int unsigned          lo,
                                     input int unsigned          hi);
    return (pos >= VGA_CNT_W'(lo)) && (pos < VGA_CNT_W'(hi));
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// ---------------------------------------------------------------------------
// pixel_tick_gen
// Purpose: divides the system clock down to the pixel rate. Produces the
//          raster-advance enable and a registered one-clk pixel strobe that
//          lines up with the counters updated on that same advance.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   o_advance_c out  combinational: raster advances on this clk edge
//   o_pix_tick  out  registered: high in the first cycle of each new position
// ---------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic o_advance_c,
  output logic o_pix_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_tick;

  assign o_advance_c = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign o_pix_tick  = r_pix_tick;

  // Divider: compare-and-wrap at CLK_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      if (o_advance_c) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      r_pix_tick <= o_advance_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Purpose: VGA raster timing generator. Column/line counters plus registered
//          sync, active-video and frame-start decodes, all describing the same
//          raster position in the same cycle.
// Ports:
//   clk        in   system clock (100 MHz)
//   reset      in   synchronous, active-high
//   hCount     out  current column, 0..H_TOTAL-1
//   vCount     out  current line, 0..V_TOTAL-1
//   bright     out  position is inside the active window
//   hSync      out  active-low horizontal sync
//   vSync      out  active-low vertical sync
//   pixTick    out  one-clk strobe in the first cycle of each new position
//   frameStart out  one-clk strobe with the pixTick at position (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned H_ACT_END   = VGA_H_ACT_END,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START,
  parameter int unsigned V_ACT_END   = VGA_V_ACT_END
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [VGA_CNT_W-1:0] hCount,
  output logic [VGA_CNT_W-1:0] vCount,
  output logic                 bright,
  output logic                 hSync,
  output logic                 vSync,
  output logic                 pixTick,
  output logic                 frameStart
);

  localparam int unsigned CNT_W = VGA_CNT_W;

  logic     w_advance;
  logic     w_pix_tick;
  vga_pos_t w_pos_nxt;

  vga_pos_t r_pos;
  logic     r_bright;
  logic     r_hsync;
  logic     r_vsync;
  logic     r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .o_advance_c (w_advance),
    .o_pix_tick  (w_pix_tick)
  );

  // Next raster position; vertical steps only on a horizontal wrap
  always_comb begin
    w_pos_nxt = r_pos;
    if (w_advance) begin
      if (r_pos.h == CNT_W'(H_TOTAL - 1)) begin
        w_pos_nxt.h = '0;
        if (r_pos.v == CNT_W'(V_TOTAL - 1)) begin
          w_pos_nxt.v = '0;
        end else begin
          w_pos_nxt.v = r_pos.v + CNT_W'(1);
        end
      end else begin
        w_pos_nxt.h = r_pos.h + CNT_W'(1);
      end
    end
  end

  // Counters and decodes share one stage; decodes use the next position so
  // every output refers to the position held in the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos         <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_bright      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pos         <= w_pos_nxt;
      r_hsync       <= !(w_pos_nxt.h < CNT_W'(H_SYNC));
      r_vsync       <= !(w_pos_nxt.v < CNT_W'(V_SYNC));
      r_bright      <= in_window(w_pos_nxt.h, H_ACT_START, H_ACT_END) &&
                       in_window(w_pos_nxt.v, V_ACT_START, V_ACT_END);
      r_frame_start <= w_advance && (w_pos_nxt.h == '0) && (w_pos_nxt.v == '0);
    end
  end

  assign hCount     = r_pos.h;
  assign vCount     = r_pos.v;
  assign bright     = r_bright;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign pixTick    = w_pix_tick;
  assign frameStart = r_frame_start;

endmodule
